hamming_decoder: RTL and testbench

HAMMING_DECODER -- requirements
Module: hamming_decoder

---
 rtl/hamming_decoder.sv | 137 +++++++++++++
 tb/tb_hamming_decoder.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hamming_decoder.sv
// ---------------------------------------------------------------------------
// hamming_decoder
//
// Two-stage pipelined Hamming(15,11) single-error-correcting decoder with a
// valid/ready handshake on both sides and a saturating count of corrected
// words.
//
// Codeword layout (bit index = 1-based position - 1):
//    bit0=p1, bit1=p2, bit2=d0, bit3=p3, bits6:4=d3:d1, bit7=p4,
//    bits14:8=d10:d4
//
// Ports:
//    clk        single clock, everything updates on the rising edge
//    rst        synchronous active-high reset
//    in_valid   upstream codeword valid
//    in_ready   block can accept a codeword this cycle
//    code_in    15-bit codeword
//    out_valid  decoded word valid
//    out_ready  downstream accepts the decoded word
//    data_out   corrected data d10:d0
//    syndrome   syndrome {s4,s3,s2,s1} of the word on data_out
//    err_corr   high when the syndrome was nonzero
//    err_count  saturating count of transferred words with err_corr=1
//    cnt_clr    synchronous clear of err_count
// ---------------------------------------------------------------------------
module hamming_decoder #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [14:0]      code_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [10:0]      data_out,
   output logic [3:0]       syndrome,
   output logic             err_corr,
   output logic [CNT_W-1:0] err_count,
   input  logic             cnt_clr
);

   // Each mask selects the codeword bits whose 1-based position has the
   // corresponding syndrome bit set in its binary index.
   localparam logic [14:0] MASK_S1 = 15'h5555;
   localparam logic [14:0] MASK_S2 = 15'h6666;
   localparam logic [14:0] MASK_S3 = 15'h7878;
   localparam logic [14:0] MASK_S4 = 15'h7F80;

   logic             s1_valid;
   logic [14:0]      s1_code;
   logic [3:0]       s1_syn;
   logic [14:0]      flip_mask;
   logic [14:0]      fixed_code;
   logic [10:0]      s1_data;
   logic             s2_adv;
   logic             s1_adv;
   logic             out_xfer;
   logic             count_full;

   // Pipeline advance conditions. A stage may load whenever it is empty or
   // its current contents are leaving this cycle, so the chain runs at one
   // word per clock with no bubble when downstream is always ready.
   always_comb begin
      s2_adv   = !out_valid || out_ready;
      s1_adv   = !s1_valid || s2_adv;
      in_ready = s1_adv;
      out_xfer = out_valid && out_ready;
   end

   // Syndrome of the word held in stage 1. A nonzero value is the 1-based
   // position of the bit presumed flipped; that bit is inverted before the
   // data bits are pulled out. Parity positions (1,2,4,8) get "corrected"
   // too, which does not touch the data but still flags a correction.
   // Double errors land on some wrong position and are mis-corrected,
   // which is the intended behaviour for a pure SEC code.
   always_comb begin
      s1_syn    = {^(s1_code & MASK_S4), ^(s1_code & MASK_S3),
                   ^(s1_code & MASK_S2), ^(s1_code & MASK_S1)};
      flip_mask = '0;
      if (s1_syn != 4'd0) begin
         flip_mask = 15'd1 << (s1_syn - 4'd1);
      end
      fixed_code = s1_code ^ flip_mask;
      s1_data    = {fixed_code[14:8], fixed_code[6:4], fixed_code[2]};
   end

   // Stage 1 captures the raw codeword. Its valid bit only drops when the
   // word moves on and nothing replaces it, so a new word can load in the
   // same cycle the old one leaves.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_code  <= '0;
      end else if (s1_adv) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_code <= code_in;
         end
      end
   end

   // Stage 2 holds the corrected result. When stalled (out_valid high,
   // out_ready low) nothing here changes, which keeps data_out, syndrome
   // and err_corr stable for the downstream side.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         data_out  <= '0;
         syndrome  <= '0;
         err_corr  <= 1'b0;
      end else if (s2_adv) begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            data_out <= s1_data;
            syndrome <= s1_syn;
            err_corr <= (s1_syn != 4'd0);
         end
      end
   end

   assign count_full = (err_count == {CNT_W{1'b1}});

   // Corrected-word counter. It counts on the output handshake rather than
   // on stage loads so a stalled word is counted exactly once. A clear wins
   // over a coincident count, and the count sticks at all-ones.
   always_ff @(posedge clk) begin
      if (rst) begin
         err_count <= '0;
      end else if (cnt_clr) begin
         err_count <= '0;
      end else if (out_xfer && err_corr && !count_full) begin
         err_count <= err_count + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_hamming_decoder.sv
// ---------------------------------------------------------------------------
// tb_hamming_decoder
//
// Drives two decoder instances (default counter width and a 2-bit counter)
// with the same stimulus and checks both against a behavioural model that
// encodes words by parity rules and decodes them by XOR of set-bit
// positions, with a queue standing in for the words in flight.
// ---------------------------------------------------------------------------
module tb_hamming_decoder;

   typedef struct {
      logic [10:0] data;
      logic [3:0]  syn;
      logic        err;
      int          acc;
   } exp_t;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic        in_ready2;
   logic [14:0] code_in;
   logic        out_valid;
   logic        out_valid2;
   logic        out_ready;
   logic [10:0] data_out;
   logic [10:0] data_out2;
   logic [3:0]  syndrome;
   logic [3:0]  syndrome2;
   logic        err_corr;
   logic        err_corr2;
   logic [15:0] err_count;
   logic [1:0]  err_count2;
   logic        cnt_clr;

   int          nChecks = 0;
   int          nFails  = 0;
   int          cyc     = 0;
   int          wordsLoaded = 0;
   int          genMode = -1;
   bit          readyAtNeg = 1'b0;

   exp_t        q[$];
   int          mCount16 = 0;
   int          mCount2  = 0;
   bit          holdValid = 1'b0;
   logic [10:0] holdData;
   logic [3:0]  holdSyn;
   logic        holdErr;
   bit          expOv;
   bit          expReady;
   exp_t        front;

   hamming_decoder dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .code_in   (code_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .data_out  (data_out),
      .syndrome  (syndrome),
      .err_corr  (err_corr),
      .err_count (err_count),
      .cnt_clr   (cnt_clr)
   );

   hamming_decoder #(.CNT_W(2)) dut2 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready2),
      .code_in   (code_in),
      .out_valid (out_valid2),
      .out_ready (out_ready),
      .data_out  (data_out2),
      .syndrome  (syndrome2),
      .err_corr  (err_corr2),
      .err_count (err_count2),
      .cnt_clr   (cnt_clr)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc = cyc + 1;

   // Places data bits in the non-power-of-two positions, then sets each
   // parity bit so that its group has even parity.
   function automatic logic [14:0] encode(input logic [10:0] d);
      logic [14:0] c;
      int          k;
      int          pp;
      logic        par;
      c = '0;
      k = 0;
      for (int p = 1; p <= 15; p++) begin
         if ((p & (p - 1)) != 0) begin
            c[p-1] = d[k];
            k++;
         end
      end
      for (int b = 0; b < 4; b++) begin
         pp  = 1 << b;
         par = 1'b0;
         for (int p = 1; p <= 15; p++) begin
            if ((p & pp) != 0 && p != pp) par ^= c[p-1];
         end
         c[pp-1] = par;
      end
      return c;
   endfunction

   // Syndrome is the XOR of the 1-based positions of all set bits.
   function automatic logic [3:0] refSyndrome(input logic [14:0] c);
      logic [3:0] s;
      s = 4'd0;
      for (int p = 1; p <= 15; p++) begin
         if (c[p-1]) s ^= 4'(p);
      end
      return s;
   endfunction

   function automatic exp_t refDecode(input logic [14:0] cw);
      exp_t        e;
      logic [14:0] c;
      int          k;
      c     = cw;
      e.syn = refSyndrome(c);
      e.err = (e.syn != 4'd0);
      if (e.syn != 4'd0) c[int'(e.syn) - 1] = ~c[int'(e.syn) - 1];
      e.data = '0;
      k = 0;
      for (int p = 1; p <= 15; p++) begin
         if ((p & (p - 1)) != 0) begin
            e.data[k] = c[p-1];
            k++;
         end
      end
      e.acc = 0;
      return e;
   endfunction

   // mode 0 clean, 1 single error, 2 double error, negative picks at random.
   function automatic logic [14:0] genWord(input int mode);
      logic [14:0] c;
      int          m;
      int          b1;
      int          b2;
      c  = encode(11'($urandom()));
      m  = (mode < 0) ? int'($urandom_range(0, 2)) : mode;
      b1 = int'($urandom_range(0, 14));
      if (m >= 1) c[b1] = ~c[b1];
      if (m == 2) begin
         b2 = int'($urandom_range(0, 13));
         if (b2 >= b1) b2++;
         c[b2] = ~c[b2];
      end
      return c;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFails++;
         $display("[TB] FAIL %s: got %0h, expected %0h at cycle %0d",
                  name, act, exp, cyc);
      end
   endtask

   // One stimulus cycle: inputs change 1 time unit after the rising edge.
   // A word offered on in_valid stays put until it has been taken.
   task automatic applyStimulus(input bit wantValid, input bit oready,
                                input bit clr);
      @(posedge clk);
      #1;
      if (in_valid && readyAtNeg) in_valid = 1'b0;
      if (!in_valid && wantValid) begin
         code_in  = genWord(genMode);
         in_valid = 1'b1;
         wordsLoaded++;
      end
      out_ready = oready;
      cnt_clr   = clr;
      @(negedge clk);
      readyAtNeg = in_ready;
   endtask

   // Compare process: on every falling edge check both instances against the
   // model, then advance the model by the handshakes due at the next edge.
   always @(negedge clk) begin
      if (rst) begin
         q.delete();
         mCount16  = 0;
         mCount2   = 0;
         holdValid = 1'b0;
      end else begin
         expOv    = (q.size() > 0) && (cyc >= q[0].acc + 2);
         expReady = !((q.size() == 2) && !out_ready);
         checkOutput("out_valid", 32'(out_valid), 32'(expOv));
         checkOutput("out_valid2", 32'(out_valid2), 32'(expOv));
         checkOutput("in_ready", 32'(in_ready), 32'(expReady));
         checkOutput("in_ready2", 32'(in_ready2), 32'(expReady));
         if (expOv) begin
            front = q[0];
            checkOutput("data_out", 32'(data_out), 32'(front.data));
            checkOutput("syndrome", 32'(syndrome), 32'(front.syn));
            checkOutput("err_corr", 32'(err_corr), 32'(front.err));
            checkOutput("data_out2", 32'(data_out2), 32'(front.data));
            checkOutput("err_corr2", 32'(err_corr2), 32'(front.err));
         end
         if (holdValid) begin
            checkOutput("hold_data", 32'(data_out), 32'(holdData));
            checkOutput("hold_syndrome", 32'(syndrome), 32'(holdSyn));
            checkOutput("hold_err_corr", 32'(err_corr), 32'(holdErr));
         end
         checkOutput("err_count", 32'(err_count), 32'(mCount16));
         checkOutput("err_count2", 32'(err_count2), 32'(mCount2));

         holdValid = expOv && !out_ready;
         if (expOv) begin
            holdData = q[0].data;
            holdSyn  = q[0].syn;
            holdErr  = q[0].err;
         end
         if (cnt_clr) begin
            mCount16 = 0;
            mCount2  = 0;
         end
         if (expOv && out_ready) begin
            front = q.pop_front();
            if (front.err && !cnt_clr) begin
               if (mCount16 < 65535) mCount16++;
               if (mCount2 < 3) mCount2++;
            end
         end
         if (in_valid && expReady) begin
            front     = refDecode(code_in);
            front.acc = cyc;
            q.push_back(front);
         end
      end
   end

   initial begin
      bit found;
      int base;

      rst       = 1'b1;
      in_valid  = 1'b0;
      code_in   = '0;
      out_ready = 1'b0;
      cnt_clr   = 1'b0;

      // Hand-computed values that pin the model itself.
      checkOutput("model_encode_001", 32'(encode(11'h001)), 32'h0007);
      checkOutput("model_encode_7ff", 32'(encode(11'h7FF)), 32'h7FFF);
      checkOutput("model_syn_0003", 32'(refSyndrome(15'h0003)), 32'h3);
      checkOutput("model_syn_7f7f", 32'(refSyndrome(15'h7F7F)), 32'h8);

      // Reset state.
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      checkOutput("rst_out_valid", 32'(out_valid), 32'h0);
      checkOutput("rst_data_out", 32'(data_out), 32'h0);
      checkOutput("rst_syndrome", 32'(syndrome), 32'h0);
      checkOutput("rst_err_corr", 32'(err_corr), 32'h0);
      checkOutput("rst_err_count", 32'(err_count), 32'h0);
      checkOutput("rst_in_ready", 32'(in_ready), 32'h1);

      // Directed words, one accepted per two cycles, latency of two edges.
      out_ready = 1'b1;
      in_valid  = 1'b1;
      code_in   = 15'h0007;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      checkOutput("clean_valid", 32'(out_valid), 32'h1);
      checkOutput("clean_data", 32'(data_out), 32'h001);
      checkOutput("clean_syn", 32'(syndrome), 32'h0);
      checkOutput("clean_err", 32'(err_corr), 32'h0);
      in_valid = 1'b1;
      code_in  = 15'h0003;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      checkOutput("d0flip_data", 32'(data_out), 32'h001);
      checkOutput("d0flip_syn", 32'(syndrome), 32'h3);
      checkOutput("d0flip_err", 32'(err_corr), 32'h1);
      checkOutput("d0flip_count_before", 32'(err_count), 32'h0);
      in_valid = 1'b1;
      code_in  = 15'h7F7F;
      @(posedge clk); #1;
      in_valid = 1'b0;
      checkOutput("d0flip_count_after", 32'(err_count), 32'h1);
      @(posedge clk); #1;
      checkOutput("p4flip_data", 32'(data_out), 32'h7FF);
      checkOutput("p4flip_syn", 32'(syndrome), 32'h8);
      checkOutput("p4flip_err", 32'(err_corr), 32'h1);
      readyAtNeg = 1'b1;
      repeat (3) applyStimulus(1'b0, 1'b1, 1'b0);

      // Eight back-to-back words with downstream ready going 1,0,0,1,0,0...
      base = wordsLoaded;
      for (int k = 0; k < 60 && (wordsLoaded - base < 8 || in_valid); k++) begin
         applyStimulus(wordsLoaded - base < 8, (k % 3) == 0, 1'b0);
      end
      repeat (4) applyStimulus(1'b0, 1'b1, 1'b0);

      // Random traffic, random backpressure, occasional counter clear.
      for (int k = 0; k < 1500; k++) begin
         applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                       $urandom_range(0, 40) == 0);
      end
      repeat (4) applyStimulus(1'b0, 1'b1, 1'b0);

      // Saturation of the 2-bit counter after five corrected words.
      applyStimulus(1'b0, 1'b1, 1'b1);
      genMode = 1;
      base    = wordsLoaded;
      for (int k = 0; k < 40 && (wordsLoaded - base < 5 || in_valid); k++) begin
         applyStimulus(wordsLoaded - base < 5, 1'b1, 1'b0);
      end
      repeat (4) applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput("sat_count2", 32'(err_count2), 32'h3);
      checkOutput("sat_count16", 32'(err_count), 32'h5);

      // Clear coincident with a counted transfer.
      applyStimulus(1'b1, 1'b1, 1'b0);
      found = 1'b0;
      for (int k = 0; k < 10 && !found; k++) begin
         @(posedge clk); #1;
         in_valid = 1'b0;
         if (out_valid) begin
            cnt_clr = 1'b1;
            found   = 1'b1;
         end
      end
      if (!found) checkOutput("clr_wait_timeout", 32'h0, 32'h1);
      @(posedge clk); #1;
      cnt_clr = 1'b0;
      checkOutput("clr_wins_count2", 32'(err_count2), 32'h0);
      checkOutput("clr_wins_count16", 32'(err_count), 32'h0);
      readyAtNeg = 1'b1;
      genMode    = -1;

      // Reset with two words in flight and downstream stalled.
      repeat (3) applyStimulus(1'b1, 1'b0, 1'b0);
      in_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      checkOutput("midrst_out_valid", 32'(out_valid), 32'h0);
      checkOutput("midrst_err_count", 32'(err_count), 32'h0);
      checkOutput("midrst_in_ready", 32'(in_ready), 32'h1);
      repeat (6) applyStimulus(1'b0, 1'b1, 1'b0);

      checkOutput("drained", 32'(q.size()), 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures",
               nChecks, nFails);
      $finish;
   end

endmodule
